// File: rtl/pitch_score_pkg.sv
// Shared definitions for the pitch scoring engine.
//   state_t    - engine FSM state encoding
//   SCORE_MAX  - best per-frame score (also the penalty saturation value)
//   PEN_W      - width of a penalty / score value
package pitch_score_pkg;

  localparam int PEN_W = 4;
  localparam logic [PEN_W-1:0] SCORE_MAX = 4'd15;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STEP,
    ACCUM,
    DONE
  } state_t;

endpackage

// File: rtl/pitch_band_scorer.sv
// Band-counting scorer for one sung channel against the reference.
// On load it captures |song - ref| and the tolerance band
// b = max(ref >> BAND_SH, 1). On each step it removes one band from the
// distance and raises the penalty by one. It stops when the remaining
// distance is below one band or the penalty saturates.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   load       - capture a new channel (engine is in LOAD)
//   step       - advance one band (engine is in STEP)
//   song_f     - sung frequency of the selected channel
//   ref_f      - reference frequency
//   pen        - current penalty, 0..SCORE_MAX
//   done       - stepping finished, pen is final
//   zero_path  - song_f or ref_f is zero; pen is forced at load
module pitch_band_scorer
  import pitch_score_pkg::*;
#(
  parameter int FREQ_W  = 15,
  parameter int BAND_SH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [FREQ_W-1:0] song_f,
  input  logic [FREQ_W-1:0] ref_f,
  output logic [PEN_W-1:0]  pen,
  output logic              done,
  output logic              zero_path
);

  logic [FREQ_W-1:0] diff;
  logic [FREQ_W-1:0] band;
  logic [FREQ_W-1:0] abs_diff;
  logic [FREQ_W-1:0] shifted;
  logic [FREQ_W-1:0] band_init;

  // NOTE: every output of a combinational block is assigned on every path
  // (here unconditionally); a missed assignment would infer a latch.
  always_comb begin
    abs_diff  = (song_f >= ref_f) ? (song_f - ref_f) : (ref_f - song_f);
    shifted   = ref_f >> BAND_SH;
    // A small reference would give a zero band and an endless count.
    band_init = (shifted == '0) ? FREQ_W'(1) : shifted;
    zero_path = (song_f == '0) || (ref_f == '0);
    done      = (diff < band) || (pen == SCORE_MAX);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff <= '0;
      band <= FREQ_W'(1);
      pen  <= '0;
    end else if (load) begin
      if (zero_path) begin
        diff <= '0;
        band <= FREQ_W'(1);
        // Silence on both sides is a perfect match; silence on one side only
        // is the worst possible miss.
        pen  <= (song_f == '0 && ref_f == '0) ? '0 : SCORE_MAX;
      end else begin
        diff <= abs_diff;
        band <= band_init;
        pen  <= '0;
      end
    end else if (step && !done) begin
      // Reached only when diff >= band, so this cannot underflow.
      diff <= diff - band;
      pen  <= pen + 1'b1;
    end
  end

endmodule

// File: rtl/pitch_score_engine.sv
// Pitch scoring engine. It accepts frames of N_CH sung frequencies plus one
// reference, scores each channel 0..15 by the number of tolerance bands
// between song and reference, accumulates 2^LOG2_WIN frames, and then
// publishes the per-channel window average.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   song_din     - sung frequencies, channel c at [c*FREQ_W +: FREQ_W]
//   ref_din      - reference frequency
//   frame_valid  - song_din/ref_din hold a frame
//   frame_ready  - engine is idle and accepts a frame
//   score_avg    - per-channel window average, channel c at [c*4 +: 4]
//   score_ready  - one-cycle pulse when score_avg updates
//   frame_count  - frames accumulated in the current window
module pitch_score_engine
  import pitch_score_pkg::*;
#(
  parameter int FREQ_W   = 15,
  parameter int N_CH     = 2,
  parameter int BAND_SH  = 5,
  parameter int LOG2_WIN = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*FREQ_W-1:0] song_din,
  input  logic [FREQ_W-1:0]      ref_din,
  input  logic                   frame_valid,
  output logic                   frame_ready,
  output logic [N_CH*4-1:0]      score_avg,
  output logic                   score_ready,
  output logic [LOG2_WIN-1:0]    frame_count
);

  localparam int ACC_W = PEN_W + LOG2_WIN;
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  state_t                  state;
  logic [N_CH*FREQ_W-1:0]  song_q;
  logic [FREQ_W-1:0]       ref_q;
  logic [CH_W-1:0]         ch;
  logic [ACC_W-1:0]        acc [N_CH];

  logic [FREQ_W-1:0]       song_sel;
  logic [PEN_W-1:0]        pen;
  logic                    scorer_done;
  logic                    zero_path;
  logic [PEN_W-1:0]        frame_score;

  always_comb begin
    song_sel    = song_q[ch*FREQ_W +: FREQ_W];
    frame_score = SCORE_MAX - pen;
  end

  pitch_band_scorer #(
    .FREQ_W  (FREQ_W),
    .BAND_SH (BAND_SH)
  ) u_scorer (
    .clk       (clk),
    .rst       (rst),
    .load      (state == LOAD),
    .step      (state == STEP),
    .song_f    (song_sel),
    .ref_f     (ref_q),
    .pen       (pen),
    .done      (scorer_done),
    .zero_path (zero_path)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      frame_ready <= 1'b1;
      score_avg   <= '0;
      score_ready <= 1'b0;
      frame_count <= '0;
      ch          <= '0;
      song_q      <= '0;
      ref_q       <= '0;
      // NOTE: the accumulators are a handful of flops, not a RAM, so clearing
      // them in reset is cheap; a window must never start from stale sums.
      for (int i = 0; i < N_CH; i++) acc[i] <= '0;
    end else begin
      score_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_valid && frame_ready) begin
            song_q      <= song_din;
            ref_q       <= ref_din;
            ch          <= '0;
            frame_ready <= 1'b0;
            state       <= LOAD;
          end
        end

        LOAD: state <= zero_path ? ACCUM : STEP;

        STEP: if (scorer_done) state <= ACCUM;

        ACCUM: begin
          acc[ch] <= acc[ch] + {{LOG2_WIN{1'b0}}, frame_score};
          if (ch != LAST_CH) begin
            ch    <= ch + 1'b1;
            state <= LOAD;
          end else if (frame_count == '1) begin
            state <= DONE;
          end else begin
            frame_count <= frame_count + 1'b1;
            frame_ready <= 1'b1;
            state       <= IDLE;
          end
        end

        DONE: begin
          // The upper four accumulator bits are the sum divided by the
          // window length.
          for (int i = 0; i < N_CH; i++) begin
            score_avg[i*4 +: 4] <= acc[i][LOG2_WIN +: 4];
            acc[i]              <= '0;
          end
          frame_count <= '0;
          score_ready <= 1'b1;
          frame_ready <= 1'b1;
          state       <= IDLE;
        end

        default: begin
          frame_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pitch_score_engine.sv
// Directed bench for pitch_score_engine (FREQ_W=15, N_CH=2, BAND_SH=5,
// LOG2_WIN=2). Frame latency is measured from the accepting edge to
// frame_ready returning: the sum of per-channel latencies, plus one for the
// DONE cycle on the last frame of a window.
module tb_pitch_score_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] song_din;
  logic [14:0] ref_din;
  logic        frame_valid;
  logic        frame_ready;
  logic [7:0]  score_avg;
  logic        score_ready;
  logic [1:0]  frame_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;

  always #5 clk = ~clk;

  pitch_score_engine #(
    .FREQ_W   (15),
    .N_CH     (2),
    .BAND_SH  (5),
    .LOG2_WIN (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .song_din    (song_din),
    .ref_din     (ref_din),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .score_avg   (score_avg),
    .score_ready (score_ready),
    .frame_count (frame_count)
  );

  always @(negedge clk) if (score_ready) n_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (frame_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  // Counts edges after the accepting edge until frame_ready is back.
  task automatic wait_done(input string tag, output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (frame_ready) break;
    end
  endtask

  task automatic send_frame(input logic [14:0] s0, input logic [14:0] s1,
                            input logic [14:0] r, input int lat,
                            input logic [1:0] fc, input bit last,
                            input logic [7:0] avg, input string tag);
    int n;
    wait_ready(tag);
    song_din    = {s1, s0};
    ref_din     = r;
    frame_valid = 1'b1;
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
    wait_done(tag, n);
    check({tag, "_lat"}, n, lat);
    check({tag, "_fcount"}, frame_count, fc);
    check({tag, "_sready"}, score_ready, last);
    if (last) begin
      check({tag, "_avg"}, score_avg, avg);
      @(posedge clk);
      #1;
      check({tag, "_sready_drop"}, score_ready, 0);
      check({tag, "_avg_hold"}, score_avg, avg);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    song_din    = '0;
    ref_din     = '0;
    frame_valid = 1'b0;
    do_reset();
    check("rst_frame_ready", frame_ready, 1);
    check("rst_score_avg", score_avg, 0);
    check("rst_score_ready", score_ready, 0);
    check("rst_frame_count", frame_count, 0);

    // ref 440, songs 440/466: ch0 pen 0 (3 cycles), ch1 b=13 pen 2 (5 cycles).
    for (int f = 0; f < 4; f++)
      send_frame(15'd440, 15'd466, 15'd440, (f == 3) ? 9 : 8,
                 2'((f + 1) % 4), f == 3, 8'hDF, "basic");

    // ch0 880 vs 440: pen saturates, 18 cycles; ch1 exact, 3 cycles.
    for (int f = 0; f < 4; f++)
      send_frame(15'd880, 15'd440, 15'd440, (f == 3) ? 22 : 21,
                 2'((f + 1) % 4), f == 3, 8'hF0, "saturate");

    // Zero-frequency paths, 2 cycles each. ch0 sums 15+0+15+15=45 -> 11,
    // ch1 sums 0+0+15+0=15 -> 3.
    send_frame(15'd0,   15'd100, 15'd0,   4, 2'd1, 1'b0, 8'h00, "zero_f1");
    send_frame(15'd0,   15'd0,   15'd440, 4, 2'd2, 1'b0, 8'h00, "zero_f2");
    send_frame(15'd0,   15'd0,   15'd0,   4, 2'd3, 1'b0, 8'h00, "zero_f3");
    send_frame(15'd440, 15'd0,   15'd440, 6, 2'd0, 1'b1, 8'h3B, "zero_f4");

    // ref 20: band forced to 1; 23 and 17 both give pen 3 (6 cycles each).
    for (int f = 0; f < 4; f++)
      send_frame(15'd23, 15'd17, 15'd20, (f == 3) ? 13 : 12,
                 2'((f + 1) % 4), f == 3, 8'hCC, "min_band");

    // frame_valid held high: one capture per IDLE visit.
    song_din    = {15'd466, 15'd440};
    ref_din     = 15'd440;
    frame_valid = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_ready("hold");
      check("hold_fcount_before", frame_count, 32'(f));
      @(posedge clk);
      #1;
      wait_done("hold", n);
      check("hold_lat", n, (f == 3) ? 9 : 8);
    end
    frame_valid = 1'b0;
    check("hold_fcount_wrap", frame_count, 0);
    check("hold_sready", score_ready, 1);
    check("hold_avg", score_avg, 8'hDF);
    @(posedge clk);
    #1;

    // Reset during STEP of the third frame discards the window.
    send_frame(15'd23, 15'd17, 15'd20, 12, 2'd1, 1'b0, 8'h00, "rst_f1");
    send_frame(15'd23, 15'd17, 15'd20, 12, 2'd2, 1'b0, 8'h00, "rst_f2");
    wait_ready("rst_f3");
    song_din    = {15'd440, 15'd880};
    ref_din     = 15'd440;
    frame_valid = 1'b1;
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_frame_ready", frame_ready, 1);
    check("mid_rst_score_avg", score_avg, 0);
    check("mid_rst_score_ready", score_ready, 0);
    check("mid_rst_frame_count", frame_count, 0);

    // A full window after the reset averages only its own frames.
    for (int f = 0; f < 4; f++)
      send_frame(15'd440, 15'd466, 15'd440, (f == 3) ? 9 : 8,
                 2'((f + 1) % 4), f == 3, 8'hDF, "post_rst");

    repeat (3) @(posedge clk);
    #1;
    check("score_ready_pulses", n_pulses, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
